spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- Command/register controller behind the byte-level SPI slave.
- Decodes the byte stream from the slave (rx_data/data_valid) into register-bank reads and writes, with address auto-increment.
- Sequences the slave's transmit path (tx_data/tx_load) so the SPI master can read registers back.
- Holds the design's SPI-visible register bank and exports it as a flat bus to the rest of the FPGA.

Parameters:
NUM_REGS, 16, number of 8-bit registers (2..128); address field is the 7-bit command address.
ID_VALUE, 8'hA5, fixed read-only contents of address 0.
RESET_VALUE, 8'h00, reset contents of registers 1..NUM_REGS-1.

Ports:
clk50m  in  1  system clock, 50 MHz; the only clock.
rst  in  1  asynchronous, active-high reset.
cs  in  1  raw SPI chip select pad, active-low, asynchronous to clk50m.
rx_data  in  8  received byte from the SPI slave; valid when data_valid=1.
data_valid  in  1  one-clk50m pulse per received byte.
tx_data  out  8  next byte for the slave to shift out.
tx_load  out  1  one-cycle pulse: slave latches tx_data.
regs_flat  out  8*NUM_REGS  register contents; reg[i] = regs_flat[8*i+7:8*i].
wr_strobe  out  1  one-cycle pulse when a writable register is updated.
wr_addr  out  7  address of the last write; valid with wr_strobe.
busy  out  1  1 while a frame is active (synchronised cs low).
addr_err  out  1  sticky; set on any access to address >= NUM_REGS; cleared on rst only.

Behaviour:
- Reset values: tx_data=8'h00, tx_load=0, wr_strobe=0, wr_addr=0, busy=0, addr_err=0, FSM=IDLE, addr pointer=0.
- Register reset: reg[0]=ID_VALUE (constant); all other registers = RESET_VALUE.
- cs synchroniser:
  - cs passes through a 2-flop synchroniser; cs_s is the synchronised level.
  - The synchroniser flops reset to 1 (deasserted).
  - Falling and rising edges are detected on cs_s.
- State IDLE: busy=0; data_valid ignored.
  - On cs_s falling edge -> CMD.
  - Same cycle: tx_data <= ID_VALUE, tx_load pulses. The first byte shifted out of every frame is the ID.
- State CMD: busy=1; wait for first data_valid.
  - Command byte: bit7 = 1 write, 0 read; bits[6:0] = start address A.
  - Write command -> WRITE; addr <= A.
  - Read command -> READ; addr <= A+1.
  - Read response is registered in the cycle after the command is accepted: tx_data <= reg[A] (8'h00 if A >= NUM_REGS), tx_load pulses. Latency command-valid -> tx_load = 1 clk.
- State WRITE: each data_valid:
  - If 1 <= addr < NUM_REGS: reg[addr] <= rx_data and wr_addr <= addr; wr_strobe pulses in the next cycle.
  - addr==0: write silently dropped, no strobe, no error.
  - addr >= NUM_REGS: dropped, addr_err <= 1.
  - Then addr <= addr+1, modulo 128 (7-bit wrap, 127 -> 0).
- State READ: each data_valid (rx byte is don't-care):
  - Next cycle: tx_data <= reg[addr] (8'h00 and addr_err <= 1 if addr >= NUM_REGS), tx_load pulses.
  - Then addr <= addr+1 mod 128.
  - The read of A in CMD also sets addr_err if A >= NUM_REGS.
- Any state: cs_s rising edge -> IDLE on the next clock, busy <= 0.
  - A write already committed stays committed; the partial frame is simply ended.
  - A data_valid coinciding with the cs_s rising edge is still processed in that cycle, then IDLE.
- cs_s falling edge while not IDLE (glitch-free re-select) forces CMD and reloads the ID, exactly as from IDLE.
- Back-to-back data_valid on consecutive cycles must be handled without loss: one byte per clock throughput.
- Writes never overlap reads: a frame is entirely read or entirely write.
- Reset asserted mid-frame: everything returns to reset values immediately (async), including register contents.
- regs_flat is driven directly from the register flops, with no extra latency: a write is visible one clk after its data_valid.

Test Plan:
- Reset, then idle with cs=1 and random data_valid pulses -> regs_flat all 8'h00 except reg0=8'hA5; no wr_strobe, tx_load, or busy activity.
- cs low, bytes 8'h83,8'h11,8'h22 -> reg3=8'h11, reg4=8'h22; two wr_strobe pulses with wr_addr 3 then 4; tx_load with 8'hA5 after cs falls (+2-3 clk); busy drops 3 clk after cs rises.
- After the previous case, new frame with bytes 8'h03,x,x -> tx_load sequence 8'hA5, 8'h11, 8'h22, 8'h00 (reg5), each 1 clk after the corresponding data_valid.
- Write frame 8'h8F,8'h55,8'h66,8'h77 with NUM_REGS=16 -> reg15=8'h55; addresses 16,17 dropped; addr_err=1 and stays 1 across later good frames until rst.
- Write frame 8'h80,8'hFF -> reg0 remains 8'hA5, no wr_strobe, addr_err stays 0; then read frame 8'h7F (NUM_REGS=16) -> tx 8'h00, next byte wraps to reg0 = 8'hA5, addr_err=1.
- Mid-frame abort: cs rises after the command 8'h85 and one data byte 8'h9C, then reset pulsed mid-frame during a second write frame -> reg5=8'h9C before reset; all outputs and registers at reset values after rst; the next frame starts cleanly in CMD.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder and register bank: byte-stream writes/reads with 7-bit auto-increment.
// Read data is loaded 1 clk after its data_valid; no backpressure, one byte per clock.
module spi_reg_ctrl #(
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic                  clk50m,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [7:0]            rx_data,
  input  logic                  data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_load,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int         IW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREGS = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t     state, state_nxt;
  logic       cs_q1, cs_s, cs_d;
  logic       cs_fall, cs_rise;
  logic [6:0] addr, addr_nxt;
  logic [7:0] regs [NUM_REGS];
  logic [7:0] tx_data_nxt;
  logic       tx_load_nxt;
  logic       wr_en;
  logic       wr_strobe_nxt;
  logic [6:0] wr_addr_nxt;
  logic       addr_err_nxt;
  logic [6:0] rd_addr;
  logic       rd_oob;
  logic [7:0] rd_byte;
  logic       addr_ok;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  // cs_d holds the previous synchronised level for edge detection.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      cs_q1 <= 1'b1;
      cs_s  <= 1'b1;
      cs_d  <= 1'b1;
    end else begin
      cs_q1 <= cs;
      cs_s  <= cs_q1;
      cs_d  <= cs_s;
    end
  end

  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;
  assign busy    = (state != IDLE);

  // In CMD the read address comes straight from the command byte.
  assign rd_addr = (state == CMD) ? rx_data[6:0] : addr;
  assign rd_oob  = !in_range(rd_addr);
  assign rd_byte = rd_oob ? 8'h00 : regs[rd_addr[IW-1:0]];
  assign addr_ok = in_range(addr);

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    tx_data_nxt   = tx_data;
    tx_load_nxt   = 1'b0;
    wr_en         = 1'b0;
    wr_strobe_nxt = 1'b0;
    wr_addr_nxt   = wr_addr;
    addr_err_nxt  = addr_err;
    if (cs_fall) begin
      state_nxt   = CMD;
      tx_data_nxt = ID_VALUE;
      tx_load_nxt = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        CMD: if (data_valid) begin
          if (rx_data[7]) begin
            state_nxt = WRITE;
            addr_nxt  = rx_data[6:0];
          end else begin
            state_nxt    = READ;
            addr_nxt     = rx_data[6:0] + 7'd1;
            tx_data_nxt  = rd_byte;
            tx_load_nxt  = 1'b1;
            addr_err_nxt = addr_err | rd_oob;
          end
        end
        WRITE: if (data_valid) begin
          if (!addr_ok) begin
            addr_err_nxt = 1'b1;
          end else if (addr != 7'd0) begin
            wr_en         = 1'b1;
            wr_strobe_nxt = 1'b1;
            wr_addr_nxt   = addr;
          end
          addr_nxt = addr + 7'd1;
        end
        READ: if (data_valid) begin
          tx_data_nxt  = rd_byte;
          tx_load_nxt  = 1'b1;
          addr_err_nxt = addr_err | rd_oob;
          addr_nxt     = addr + 7'd1;
        end
      endcase
      if (cs_rise) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= 7'd0;
      tx_data   <= 8'h00;
      tx_load   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      tx_data   <= tx_data_nxt;
      tx_load   <= tx_load_nxt;
      wr_strobe <= wr_strobe_nxt;
      wr_addr   <= wr_addr_nxt;
      addr_err  <= addr_err_nxt;
    end
  end

  // Register 0 is never write-enabled, so it keeps the ID constant.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == 0) ? ID_VALUE : RESET_VALUE;
    end else if (wr_en) begin
      regs[addr[IW-1:0]] <= rx_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: expected tx bytes and writes are queued as frames are driven.
module tb_spi_reg_ctrl;

  logic         clk50m = 1'b0;
  logic         rst = 1'b1;
  logic         cs = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         data_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_load;
  logic [127:0] regs_flat;
  logic         wr_strobe;
  logic [6:0]   wr_addr;
  logic         busy;
  logic         addr_err;

  spi_reg_ctrl #(.NUM_REGS(16), .ID_VALUE(8'hA5), .RESET_VALUE(8'h00)) dut (
    .clk50m(clk50m), .rst(rst), .cs(cs), .rx_data(rx_data), .data_valid(data_valid),
    .tx_data(tx_data), .tx_load(tx_load), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .busy(busy), .addr_err(addr_err)
  );

  always #10 clk50m = ~clk50m;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [8:0]  tx_q [$];
  logic [15:0] wr_q [$];
  logic [7:0]  data_q [$];
  logic [7:0]  mdl [16];
  logic        err_exp = 1'b0;
  logic        dv_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] mrd(input logic [6:0] a);
    return ({1'b0, a} < 8'd16) ? mdl[a[3:0]] : 8'h00;
  endfunction

  always @(posedge clk50m) dv_q <= data_valid;

  // tx bytes carry the data_valid seen at the loading edge, pinning the 1-clk latency.
  always @(negedge clk50m) begin
    if (!rst && tx_load) begin
      if (tx_q.size() == 0) check("tx_unexpected", 32'(tx_load), 32'd0);
      else check("tx_byte", 32'({dv_q, tx_data}), 32'(tx_q.pop_front()));
    end
    if (!rst && wr_strobe) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'(wr_strobe), 32'd0);
      else check("wr_event", 32'({dv_q, wr_addr, regs_flat[8*int'(wr_addr) +: 8]}),
                 32'(wr_q.pop_front()));
    end
  end

  task automatic reset_model();
    for (int i = 0; i < 16; i++) mdl[i] = (i == 0) ? 8'hA5 : 8'h00;
    err_exp = 1'b0;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) check($sformatf("reg%0d", i), 32'(regs_flat[8*i +: 8]), 32'(mdl[i]));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    data_valid = 1'b1;
    @(posedge clk50m); #2;
    data_valid = 1'b0;
  endtask

  task automatic cs_low();
    int lat = 0;
    tx_q.push_back({1'b0, 8'hA5});
    cs = 1'b0;
    while (lat < 8) begin
      @(posedge clk50m); lat++; #1;
      if (tx_load) break;
    end
    check("id_latency_2to3", 32'(lat >= 2 && lat <= 3), 32'd1);
    @(posedge clk50m); #2;
  endtask

  task automatic cs_high();
    cs = 1'b1;
    @(posedge clk50m); @(posedge clk50m); #1;
    check("busy_hold", 32'(busy), 32'd1);
    @(posedge clk50m); #1;
    check("busy_drop", 32'(busy), 32'd0);
    @(posedge clk50m); #2;
  endtask

  task automatic wr_body(input logic [6:0] a);
    logic [6:0] ad;
    send_byte({1'b1, a});
    for (int k = 0; k < data_q.size(); k++) begin
      ad = a + 7'(k);
      if ({1'b0, ad} >= 8'd16) err_exp = 1'b1;
      else if (ad != 7'd0) begin
        wr_q.push_back({1'b1, ad, data_q[k]});
        mdl[ad[3:0]] = data_q[k];
      end
      send_byte(data_q[k]);
    end
  endtask

  task automatic rd_body(input logic [6:0] a, input int n);
    logic [6:0] ad;
    for (int k = 0; k <= n; k++) begin
      ad = a + 7'(k);
      tx_q.push_back({1'b1, mrd(ad)});
      if ({1'b0, ad} >= 8'd16) err_exp = 1'b1;
    end
    send_byte({1'b0, a});
    for (int k = 0; k < n; k++) send_byte(8'($urandom));
  endtask

  task automatic do_reset();
    check("queues_drained", 32'(tx_q.size() + wr_q.size()), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_load", 32'(tx_load), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    tx_q.delete();
    wr_q.delete();
    reset_model();
    check_regs();
    cs = 1'b1;
    data_valid = 1'b0;
    repeat (3) @(posedge clk50m);
    #2 rst = 1'b0;
    @(posedge clk50m); #2;
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_model();
    repeat (3) @(posedge clk50m);
    #2;
    do_reset();

    // Idle with cs high: data_valid must be ignored.
    for (int i = 0; i < 20; i++) begin
      data_valid = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      @(posedge clk50m); #2;
      check("idle_busy", 32'(busy), 32'd0);
    end
    data_valid = 1'b0;
    repeat (3) @(posedge clk50m);
    #2;
    check_regs();

    // Write 3,4 back-to-back.
    cs_low();
    data_q = '{8'h11, 8'h22};
    wr_body(7'h03);
    cs_high();
    check_regs();
    check("err_after_wr34", 32'(addr_err), 32'(err_exp));

    // Read back from 3 with auto-increment.
    cs_low();
    rd_body(7'h03, 2);
    cs_high();
    check("err_after_rd3", 32'(addr_err), 32'(err_exp));

    // Write to the ID register is dropped silently.
    cs_low();
    data_q = '{8'hFF};
    wr_body(7'h00);
    cs_high();
    check_regs();
    check("err_after_wr0", 32'(addr_err), 32'd0);

    // Out-of-range read, then 7-bit wrap to address 0.
    cs_low();
    rd_body(7'h7F, 1);
    cs_high();
    check("err_after_rd7f", 32'(addr_err), 32'd1);

    do_reset();

    // Write running off the end of the bank.
    cs_low();
    data_q = '{8'h55, 8'h66, 8'h77};
    wr_body(7'h0F);
    cs_high();
    check_regs();
    check("err_after_wr15", 32'(addr_err), 32'd1);
    cs_low();
    data_q = '{8'h42};
    wr_body(7'h01);
    cs_high();
    check_regs();
    check("err_sticky", 32'(addr_err), 32'(err_exp));

    do_reset();

    // Abort after one data byte, then reset in the middle of a frame.
    cs_low();
    data_q = '{8'h9C};
    wr_body(7'h05);
    cs_high();
    check_regs();
    cs_low();
    data_q = '{8'h12};
    wr_body(7'h06);
    repeat (2) @(posedge clk50m);
    #2;
    check("busy_mid_frame", 32'(busy), 32'd1);
    do_reset();

    cs_low();
    rd_body(7'h05, 2);
    cs_high();
    check("err_final", 32'(addr_err), 32'd0);
    check("queues_final", 32'(tx_q.size() + wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
